// File: rtl/mfrc522_pkg.sv
// ============================================================================
//  Module      : mfrc522_pkg
//  Description : Shared constants, state encoding and address-byte helpers
//                for the MFRC522 SPI register-interface responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mfrc522_pkg;

    // Register addresses with non-zero reset values or special handling
    localparam logic [5:0] RESERVED_REG = 6'h00;
    localparam logic [5:0] COMMAND      = 6'h01;
    localparam logic [5:0] COMIEN       = 6'h02;
    localparam logic [5:0] MODE         = 6'h11;
    localparam logic [5:0] TXCONTROL    = 6'h14;
    localparam logic [5:0] VERSION_REG  = 6'h37;

    // Reset values of those registers
    localparam logic [7:0] COMMAND_RST   = 8'h20;
    localparam logic [7:0] COMIEN_RST    = 8'h80;
    localparam logic [7:0] MODE_RST      = 8'h3F;
    localparam logic [7:0] TXCONTROL_RST = 8'h80;
    localparam logic [7:0] VERSION_DEF   = 8'h92;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        DATA_RD = 2'd2,
        DATA_WR = 2'd3
    } state_t;

    // Address byte bit7: 1 = read, 0 = write
    function automatic logic addr_is_read(input logic [7:0] b);
        return b[7];
    endfunction

    // Address byte bits 6:1 carry the register address; bit0 is ignored
    function automatic logic [5:0] addr_field(input logic [7:0] b);
        return b[6:1];
    endfunction

    // Reserved and version registers never accept writes
    function automatic logic addr_writable(input logic [5:0] a);
        return (a != RESERVED_REG) && (a != VERSION_REG);
    endfunction

    // Power-on content of each register
    function automatic logic [7:0] reset_value(input logic [5:0] a, input logic [7:0] version);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            COMMAND:     v = COMMAND_RST;
            COMIEN:      v = COMIEN_RST;
            MODE:        v = MODE_RST;
            TXCONTROL:   v = TXCONTROL_RST;
            VERSION_REG: v = version;
            default:     v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mfrc522_spi_responder_if.sv
// ============================================================================
//  Module      : mfrc522_spi_responder_if
//  Description : SPI pins plus fabric-side write strobe and status of the
//                MFRC522 responder. master = initiator/fabric view,
//                slave = responder view.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mfrc522_spi_responder_if;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] xfer_count;

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi,
        input  spi_miso, spi_miso_oe, wr_valid, wr_addr, wr_data, busy, xfer_count
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi,
        output spi_miso, spi_miso_oe, wr_valid, wr_addr, wr_data, busy, xfer_count
    );
endinterface

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Two-flop synchronizer for an asynchronous SPI pin with a
//                delay stage giving single-cycle rise/fall pulses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sync_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic din,
    output logic      level,
    output logic      rise,
    output logic      fall
);

    logic meta;
    logic sync;
    logic prev;

    // Resetting to 0 means a CS held low through reset produces no fall
    // edge, so the responder waits for CS to go high before the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

`default_nettype wire

// File: rtl/mfrc522_spi_responder.sv
// ============================================================================
//  Module      : mfrc522_spi_responder
//  Description : SPI mode-0 target emulating the MFRC522 register interface:
//                64x8 register file, address-byte protocol, multi-read,
//                write strobe to fabric and transaction counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mfrc522_spi_responder
    import mfrc522_pkg::*;
#(
    parameter logic [7:0] VERSION = 8'h92,
    parameter int         CLK_HZ  = 25_000_000
) (
    input  wire logic              clk_25mhz,
    input  wire logic              rst,
    mfrc522_spi_responder_if.slave bus
);

    // CLK_HZ only documents the oversampling ratio (SCLK <= CLK_HZ/8)
    if (CLK_HZ <= 0) begin : g_clk_hz_invalid
        $error("CLK_HZ must be positive");
    end

    logic sclk_level_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_level_unused;
    logic cs_rise;
    logic cs_fall;
    logic mosi_level;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    spi_sync_edge u_sync_sclk (
        .clk   (clk_25mhz),
        .rst   (rst),
        .din   (bus.spi_sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk   (clk_25mhz),
        .rst   (rst),
        .din   (bus.spi_cs_n),
        .level (cs_level_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge u_sync_mosi (
        .clk   (clk_25mhz),
        .rst   (rst),
        .din   (bus.spi_mosi),
        .level (mosi_level),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    state_t      state;
    state_t      state_next;
    logic [7:0]  regfile [64];
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [7:0]  prefetch;
    logic [5:0]  addr;
    logic        addr_done;
    logic        miso_oe;
    logic        wr_valid;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  xfer_count;

    logic [7:0]  rx_byte;
    logic        byte_done;

    // Read view of the register file with the fixed-value addresses
    function automatic logic [7:0] reg_read(input logic [5:0] a);
        logic [7:0] v;
        if (a == VERSION_REG) begin
            v = VERSION;
        end else if (a == RESERVED_REG) begin
            v = 8'h00;
        end else begin
            v = regfile[a];
        end
        return v;
    endfunction

    assign rx_byte   = {rx_shift, mosi_level};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !cs_rise;

    // State register
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; CS rise dominates any coincident SCLK edge
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    state_next = addr_is_read(rx_byte) ? DATA_RD : DATA_WR;
                end
            end
            DATA_RD, DATA_WR: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift registers, register file, write strobe and transaction counter
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                regfile[i] <= reset_value(6'(i), VERSION);
            end
            bit_cnt    <= 3'd0;
            rx_shift   <= 7'd0;
            tx_shift   <= 8'h00;
            prefetch   <= 8'h00;
            addr       <= 6'd0;
            addr_done  <= 1'b0;
            miso_oe    <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= 6'd0;
            wr_data    <= 8'h00;
            xfer_count <= 8'h00;
        end else begin
            wr_valid <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    bit_cnt   <= 3'd0;
                    tx_shift  <= 8'h00;
                    prefetch  <= 8'h00;
                    addr_done <= 1'b0;
                    miso_oe   <= 1'b1;
                end
            end else if (cs_rise) begin
                // Any partial byte is simply dropped here
                miso_oe  <= 1'b0;
                tx_shift <= 8'h00;
                bit_cnt  <= 3'd0;
                if (addr_done) begin
                    xfer_count <= xfer_count + 8'd1;
                end
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            ADDR: begin
                                addr      <= addr_field(rx_byte);
                                addr_done <= 1'b1;
                                prefetch  <= addr_is_read(rx_byte) ?
                                             reg_read(addr_field(rx_byte)) : 8'h00;
                            end
                            DATA_RD: begin
                                // Each MOSI byte names the next register to stream out
                                addr     <= addr_field(rx_byte);
                                prefetch <= reg_read(addr_field(rx_byte));
                            end
                            DATA_WR: begin
                                if (addr_writable(addr)) begin
                                    regfile[addr] <= rx_byte;
                                    wr_valid      <= 1'b1;
                                    wr_addr       <= addr;
                                    wr_data       <= rx_byte;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                if (sclk_fall) begin
                    // bit_cnt == 0 on a fall means the 8th fall of a byte
                    tx_shift <= (bit_cnt == 3'd0) ? prefetch : {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    assign bus.spi_miso    = tx_shift[7];
    assign bus.spi_miso_oe = miso_oe;
    assign bus.wr_valid    = wr_valid;
    assign bus.wr_addr     = wr_addr;
    assign bus.wr_data     = wr_data;
    assign bus.busy        = (state != IDLE);
    assign bus.xfer_count  = xfer_count;

endmodule

`default_nettype wire

// File: tb/tb_mfrc522_spi_responder.sv
// ============================================================================
//  Module      : tb_mfrc522_spi_responder
//  Description : Self-checking bench for mfrc522_spi_responder. Drives SPI
//                mode-0 frames at 500 kHz and scores MISO bytes, write
//                strobes and status outputs against expected queues.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mfrc522_spi_responder;

    localparam int HALF_SCLK = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;
    int exp_xfer = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [13:0] wr_obs[$];
    logic [13:0] wr_exp[$];

    mfrc522_spi_responder_if bus ();

    mfrc522_spi_responder #(
        .VERSION (8'h92),
        .CLK_HZ  (25_000_000)
    ) dut (
        .clk_25mhz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #20 clk = ~clk;

    // Capture every write strobe the DUT emits
    always @(negedge clk) begin
        if (bus.wr_valid === 1'b1) begin
            wr_obs.push_back({bus.wr_addr, bus.wr_data});
        end
    end

    task automatic cs_begin();
        bus.spi_cs_n = 1'b0;
        #(HALF_SCLK);
    endtask

    task automatic cs_end();
        #(HALF_SCLK);
        bus.spi_cs_n = 1'b1;
        #(2 * HALF_SCLK);
    endtask

    // Shift the n most significant bits of b, returning MISO bits sampled before each rise
    task automatic shift_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            bus.spi_mosi = b[i];
            #(HALF_SCLK);
            r[i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            #(HALF_SCLK);
            bus.spi_sclk = 1'b0;
        end
    endtask

    // Full frame: every byte in tx_q, received bytes into rx_q
    task automatic spi_frame();
        logic [7:0] r;
        rx_q.delete();
        cs_begin();
        while (tx_q.size() > 0) begin
            shift_bits(tx_q.pop_front(), 8, r);
            rx_q.push_back(r);
        end
        cs_end();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", bus.spi_miso); end
        checks++;
        if (bus.spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", bus.spi_miso_oe); end
        checks++;
        if (bus.wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", bus.wr_valid); end
        checks++;
        if (bus.wr_addr !== 6'd0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", bus.wr_addr); end
        checks++;
        if (bus.wr_data !== 8'd0) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", bus.wr_data); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.xfer_count !== 8'd0) begin failures++; $display("FAIL reset_xfer got=%0d exp=0", bus.xfer_count); end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        exp_xfer = 0;
    endtask

    task automatic test_read_version();
        logic [7:0] r;
        logic [7:0] e;
        wr_obs.delete();
        rx_q.delete();
        exp_q = '{8'h00, 8'h92};
        cs_begin();
        shift_bits(8'hEE, 8, r);
        rx_q.push_back(r);
        checks++;
        if (bus.spi_miso_oe !== 1'b1) begin failures++; $display("FAIL version_oe got=%b exp=1", bus.spi_miso_oe); end
        shift_bits(8'h00, 8, r);
        rx_q.push_back(r);
        cs_end();
        exp_xfer++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL version_miso got=%h exp=%h", r, e); end
        end
        checks++;
        if (bus.xfer_count !== 8'(exp_xfer)) begin failures++; $display("FAIL version_xfer got=%0d exp=%0d", bus.xfer_count, exp_xfer); end
        checks++;
        if (wr_obs.size() != 0) begin failures++; $display("FAIL version_no_write got=%0d writes exp=0", wr_obs.size()); end
        checks++;
        if (bus.spi_miso_oe !== 1'b0) begin failures++; $display("FAIL version_oe_off got=%b exp=0", bus.spi_miso_oe); end
    endtask

    task automatic test_multi_read();
        logic [7:0] r;
        logic [7:0] e;
        wr_obs.delete();
        tx_q  = '{8'hEE, 8'hA8, 8'h84, 8'h00};
        exp_q = '{8'h00, 8'h92, 8'h80, 8'h80};
        spi_frame();
        exp_xfer++;
        checks++;
        if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL multi_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL multi_miso got=%h exp=%h", r, e); end
        end
        checks++;
        if (bus.xfer_count !== 8'(exp_xfer)) begin failures++; $display("FAIL multi_xfer got=%0d exp=%0d", bus.xfer_count, exp_xfer); end
        checks++;
        if (wr_obs.size() != 0) begin failures++; $display("FAIL multi_no_write got=%0d writes exp=0", wr_obs.size()); end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        logic [7:0] e;
        int         n;
        wr_obs.delete();
        cs_begin();
        shift_bits(8'h22, 8, r);
        shift_bits(8'hAA, 5, r);
        #(HALF_SCLK);
        @(negedge clk);
        bus.spi_cs_n = 1'b1;
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.busy === 1'b0) break;
        end
        checks++;
        if (n != 3) begin failures++; $display("FAIL abort_busy_drop got=%0d cycles exp=3", n); end
        #(2 * HALF_SCLK);
        exp_xfer++;
        checks++;
        if (wr_obs.size() != 0) begin failures++; $display("FAIL abort_no_write got=%0d writes exp=0", wr_obs.size()); end
        checks++;
        if (bus.xfer_count !== 8'(exp_xfer)) begin failures++; $display("FAIL abort_xfer got=%0d exp=%0d", bus.xfer_count, exp_xfer); end
        tx_q  = '{8'hA2, 8'h00};
        exp_q = '{8'h00, 8'h3F};
        spi_frame();
        exp_xfer++;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL abort_readback got=%h exp=%h", r, e); end
        end
    endtask

    task automatic test_write_read_mode();
        logic [7:0]  r;
        logic [7:0]  e;
        logic [13:0] we;
        logic [13:0] wo;
        wr_obs.delete();
        wr_exp.delete();
        tx_q  = '{8'h22, 8'h55};
        exp_q = '{8'h00, 8'h00};
        wr_exp.push_back({6'h11, 8'h55});
        spi_frame();
        exp_xfer++;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL write_miso got=%h exp=%h", r, e); end
        end
        checks++;
        if (wr_obs.size() != wr_exp.size()) begin failures++; $display("FAIL write_count got=%0d exp=%0d", wr_obs.size(), wr_exp.size()); end
        while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
            we = wr_exp.pop_front();
            wo = wr_obs.pop_front();
            checks++;
            if (wo !== we) begin failures++; $display("FAIL write_strobe got addr=%h data=%h exp addr=%h data=%h", wo[13:8], wo[7:0], we[13:8], we[7:0]); end
        end
        tx_q  = '{8'hA2, 8'h00};
        exp_q = '{8'h00, 8'h55};
        spi_frame();
        exp_xfer++;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL mode_readback got=%h exp=%h", r, e); end
        end
        checks++;
        if (bus.xfer_count !== 8'(exp_xfer)) begin failures++; $display("FAIL write_xfer got=%0d exp=%0d", bus.xfer_count, exp_xfer); end
    endtask

    task automatic test_protected();
        logic [7:0] r;
        logic [7:0] e;
        wr_obs.delete();
        tx_q = '{8'h6E, 8'h00};
        spi_frame();
        tx_q = '{8'h00, 8'h12};
        spi_frame();
        exp_xfer += 2;
        checks++;
        if (wr_obs.size() != 0) begin failures++; $display("FAIL protected_no_write got=%0d writes exp=0", wr_obs.size()); end
        tx_q  = '{8'hEE, 8'h00};
        exp_q = '{8'h00, 8'h92};
        spi_frame();
        tx_q  = '{8'h80, 8'h00};
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        // rx_q only keeps the latest frame, so gather the version frame first
        while (exp_q.size() > 2 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL protected_version got=%h exp=%h", r, e); end
        end
        spi_frame();
        exp_xfer += 2;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL protected_reserved got=%h exp=%h", r, e); end
        end
        checks++;
        if (bus.xfer_count !== 8'(exp_xfer)) begin failures++; $display("FAIL protected_xfer got=%0d exp=%0d", bus.xfer_count, exp_xfer); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] r;
        logic [7:0] e;
        wr_obs.delete();
        cs_begin();
        shift_bits(8'h22, 8, r);
        shift_bits(8'h55, 2, r);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.spi_miso, bus.spi_miso_oe, bus.wr_valid, bus.busy} !== 4'b0000)
        begin failures++; $display("FAIL midrst_bits got miso/oe/wv/busy=%b exp=0000", {bus.spi_miso, bus.spi_miso_oe, bus.wr_valid, bus.busy}); end
        checks++;
        if ({bus.wr_addr, bus.wr_data, bus.xfer_count} !== 22'd0)
        begin failures++; $display("FAIL midrst_words got addr=%h data=%h xfer=%0d exp=0", bus.wr_addr, bus.wr_data, bus.xfer_count); end
        rst = 1'b0;
        exp_xfer = 0;
        shift_bits(8'h15, 6, r);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_ignored_busy got=%b exp=0", bus.busy); end
        cs_end();
        checks++;
        if (wr_obs.size() != 0) begin failures++; $display("FAIL midrst_no_write got=%0d writes exp=0", wr_obs.size()); end
        checks++;
        if (bus.xfer_count !== 8'd0) begin failures++; $display("FAIL midrst_xfer got=%0d exp=0", bus.xfer_count); end
        tx_q  = '{8'hA2, 8'h00};
        exp_q = '{8'h00, 8'h3F};
        spi_frame();
        exp_xfer++;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL midrst_readback got=%h exp=%h", r, e); end
        end
        checks++;
        if (bus.xfer_count !== 8'(exp_xfer)) begin failures++; $display("FAIL midrst_xfer_after got=%0d exp=%0d", bus.xfer_count, exp_xfer); end
    endtask

    initial begin
        test_reset();
        test_read_version();
        test_multi_read();
        test_abort();
        test_write_read_mode();
        test_protected();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
